// File: rtl/e_stage.sv
// Y86-64 execute stage: ALU operand selection, ALU, condition codes,
// branch/cmov condition evaluation and the E->M pipeline register.
module e_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic [3:0]  e_ifun,
    input  logic [63:0] e_valC,
    input  logic [63:0] e_valA,
    input  logic [63:0] e_valB,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic [2:0]  mem_stat,
    input  logic [2:0]  wb_stat,
    input  logic        M_bubble,
    output logic [63:0] ex_valE,
    output logic [3:0]  ex_dstE,
    output logic        ex_Cnd,
    output logic [2:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        ZF,
    output logic        SF,
    output logic        OF
);
    localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
    localparam logic [3:0] R_NONE = 4'hF;

    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic        of_next, set_cc, cond;

    always_comb begin
        unique case (e_icode)
            4'h2, 4'h6:       alu_a = e_valA;
            4'h3, 4'h4, 4'h5: alu_a = e_valC;
            4'h8, 4'hA:       alu_a = -64'sd8;
            4'h9, 4'hB:       alu_a = 64'd8;
            default:          alu_a = '0;
        endcase
    end

    always_comb begin
        unique case (e_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = e_valB;
            default:                                  alu_b = '0;
        endcase
    end

    assign alu_fun = (e_icode == 4'h6) ? e_ifun : 4'h0;

    always_comb begin
        ex_valE = '0;
        of_next = 1'b0;
        unique case (alu_fun)
            4'h0: begin
                ex_valE = alu_b + alu_a;
                of_next = (alu_a[63] == alu_b[63]) && (ex_valE[63] != alu_a[63]);
            end
            4'h1: begin
                ex_valE = alu_b - alu_a;
                of_next = (alu_a[63] != alu_b[63]) && (ex_valE[63] != alu_b[63]);
            end
            4'h2:    ex_valE = alu_b & alu_a;
            4'h3:    ex_valE = alu_b ^ alu_a;
            default: ex_valE = '0;
        endcase
    end

    // A faulting instruction further down the pipe must not see CC side effects.
    assign set_cc = (e_icode == 4'h6)
                 && !(mem_stat inside {S_HLT, S_ADR, S_INS})
                 && !(wb_stat  inside {S_HLT, S_ADR, S_INS});

    always_comb begin
        unique case (e_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (SF ^ OF) | ZF;
            4'h2:    cond = SF ^ OF;
            4'h3:    cond = ZF;
            4'h4:    cond = ~ZF;
            4'h5:    cond = ~(SF ^ OF);
            4'h6:    cond = ~(SF ^ OF) & ~ZF;
            default: cond = 1'b0;
        endcase
    end

    assign ex_Cnd  = (e_icode == 4'h2 || e_icode == 4'h7) ? cond : 1'b0;
    assign ex_dstE = (e_icode == 4'h2 && !ex_Cnd) ? R_NONE : e_dstE;

    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            M_stat  <= S_AOK;
            M_icode <= 4'h1;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
        end else begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_Cnd   <= ex_Cnd;
            M_valE  <= ex_valE;
            M_valA  <= e_valA;
            M_dstE  <= ex_dstE;
            M_dstM  <= e_dstM;
        end
    end

    // CC update is independent of bubbling; only reset overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ZF <= 1'b1;
            SF <= 1'b0;
            OF <= 1'b0;
        end else if (set_cc) begin
            ZF <= (ex_valE == 64'd0);
            SF <= ex_valE[63];
            OF <= of_next;
        end
    end
endmodule

// File: tb/tb_e_stage.sv
// Randomized and directed check of e_stage against an arithmetic reference model.
module tb_e_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  e_stat, mem_stat, wb_stat;
    logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM;
    logic [63:0] e_valC, e_valA, e_valB;
    logic        M_bubble;
    logic [63:0] ex_valE, M_valE, M_valA;
    logic [3:0]  ex_dstE, M_icode, M_dstE, M_dstM;
    logic        ex_Cnd, M_Cnd, ZF, SF, OF;
    logic [2:0]  M_stat;

    int checks = 0;
    int errors = 0;

    // model state
    logic mzf, msf, mof;

    always #5 clk = ~clk;

    e_stage dut (
        .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_valC(e_valC), .e_valA(e_valA), .e_valB(e_valB), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .mem_stat(mem_stat), .wb_stat(wb_stat), .M_bubble(M_bubble),
        .ex_valE(ex_valE), .ex_dstE(ex_dstE), .ex_Cnd(ex_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .ZF(ZF), .SF(SF), .OF(OF)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_fault(input logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    // One cycle: apply inputs, check combinational outputs, clock, check registers.
    task automatic step(input logic r, input logic bub, input logic [2:0] st,
                        input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [2:0] ms, input logic [2:0] ws);
        logic [63:0] opa, opb, res;
        logic signed [64:0] wide;
        logic ovf, cnd, lt, le, setcc;
        logic [3:0] fun, xde;
        rst = r; M_bubble = bub; e_stat = st; e_icode = ic; e_ifun = fn;
        e_valC = c; e_valA = a; e_valB = b; e_dstE = de; e_dstM = dm;
        mem_stat = ms; wb_stat = ws;
        #1;
        opa = 64'd0; opb = 64'd0;
        if (ic == 4'h2 || ic == 4'h6) opa = a;
        else if (ic >= 4'h3 && ic <= 4'h5) opa = c;
        else if (ic == 4'h8 || ic == 4'hA) opa = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (ic == 4'h9 || ic == 4'hB) opa = 64'd8;
        if ((ic >= 4'h4 && ic <= 4'h6) || (ic >= 4'h8 && ic <= 4'hB)) opb = b;
        fun = (ic == 4'h6) ? fn : 4'h0;
        res = 64'd0; ovf = 1'b0;
        if (fun == 4'h0) begin
            wide = $signed({opb[63], opb}) + $signed({opa[63], opa});
            res = wide[63:0];
            ovf = wide > 65'sh0_7FFF_FFFF_FFFF_FFFF || wide < -65'sh0_8000_0000_0000_0000;
        end else if (fun == 4'h1) begin
            wide = $signed({opb[63], opb}) - $signed({opa[63], opa});
            res = wide[63:0];
            ovf = wide > 65'sh0_7FFF_FFFF_FFFF_FFFF || wide < -65'sh0_8000_0000_0000_0000;
        end else if (fun == 4'h2) res = opb & opa;
        else if (fun == 4'h3) res = opb ^ opa;
        lt = msf ^ mof;
        le = lt | mzf;
        case (fn)
            4'h0: cnd = 1'b1;
            4'h1: cnd = le;
            4'h2: cnd = lt;
            4'h3: cnd = mzf;
            4'h4: cnd = !mzf;
            4'h5: cnd = !lt;
            4'h6: cnd = !le;
            default: cnd = 1'b0;
        endcase
        if (!(ic == 4'h2 || ic == 4'h7)) cnd = 1'b0;
        xde = (ic == 4'h2 && !cnd) ? 4'hF : de;
        chk("ex_valE", ex_valE, res);
        chk("ex_Cnd", {63'd0, ex_Cnd}, {63'd0, cnd});
        chk("ex_dstE", {60'd0, ex_dstE}, {60'd0, xde});
        setcc = ic == 4'h6 && !is_fault(ms) && !is_fault(ws);
        if (r) begin
            mzf = 1'b1; msf = 1'b0; mof = 1'b0;
        end else if (setcc) begin
            mzf = (res == 64'd0); msf = res[63]; mof = ovf;
        end
        @(posedge clk);
        #1;
        if (r || bub) begin
            chk("M_stat", {61'd0, M_stat}, 64'd1);
            chk("M_icode", {60'd0, M_icode}, 64'd1);
            chk("M_Cnd", {63'd0, M_Cnd}, 64'd0);
            chk("M_valE", M_valE, 64'd0);
            chk("M_valA", M_valA, 64'd0);
            chk("M_dstE", {60'd0, M_dstE}, 64'hF);
            chk("M_dstM", {60'd0, M_dstM}, 64'hF);
        end else begin
            chk("M_stat", {61'd0, M_stat}, {61'd0, st});
            chk("M_icode", {60'd0, M_icode}, {60'd0, ic});
            chk("M_Cnd", {63'd0, M_Cnd}, {63'd0, cnd});
            chk("M_valE", M_valE, res);
            chk("M_valA", M_valA, a);
            chk("M_dstE", {60'd0, M_dstE}, {60'd0, xde});
            chk("M_dstM", {60'd0, M_dstM}, {60'd0, dm});
        end
        chk("ZF", {63'd0, ZF}, {63'd0, mzf});
        chk("SF", {63'd0, SF}, {63'd0, msf});
        chk("OF", {63'd0, OF}, {63'd0, mof});
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'(($urandom_range(0, 15)));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        mzf = 1'b1; msf = 1'b0; mof = 1'b0;
        // reset with garbage inputs
        step(1, 0, 3'd4, 4'h6, 4'h1, 64'd5, 64'd9, 64'd3, 4'd2, 4'd4, 3'd1, 3'd1);
        step(1, 1, 3'd1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'd2, 4'd4, 3'd1, 3'd1);
        chk("rst_ZF", {63'd0, ZF}, 64'd1);

        // add overflow into sign bit
        step(0, 0, 3'd1, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, 4'hF, 3'd1, 3'd1);
        chk("add_ovf_valE", M_valE, 64'h8000_0000_0000_0000);
        chk("add_ovf_flags", {61'd0, ZF, SF, OF}, 64'b011);

        // sub equal then je / jne
        step(0, 0, 3'd1, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'd2, 4'hF, 3'd1, 3'd1);
        chk("sub_eq_flags", {61'd0, ZF, SF, OF}, 64'b100);
        step(0, 0, 3'd1, 4'h7, 4'h3, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1);
        chk("je_taken", {63'd0, M_Cnd}, 64'd1);
        step(0, 0, 3'd1, 4'h7, 4'h4, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1);
        chk("jne_not_taken", {63'd0, M_Cnd}, 64'd0);

        // clear all flags, then cmovle not taken
        step(0, 0, 3'd1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'd2, 4'hF, 3'd1, 3'd1);
        step(0, 0, 3'd1, 4'h2, 4'h1, 64'd0, 64'd7, 64'd0, 4'd3, 4'hF, 3'd1, 3'd1);
        chk("cmovle_dstE", {60'd0, M_dstE}, 64'hF);

        // xor with a faulting instruction in Memory leaves CC alone
        step(0, 0, 3'd1, 4'h6, 4'h3, 64'd0, 64'hF0, 64'hF0, 4'd1, 4'hF, 3'd3, 3'd1);
        chk("xor_inhibit_icode", {60'd0, M_icode}, 64'h6);
        chk("xor_inhibit_ZF", {63'd0, ZF}, 64'd0);
        step(0, 0, 3'd4, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'd1, 4'hF, 3'd1, 3'd2);

        // stack pointer arithmetic
        step(0, 0, 3'd1, 4'h8, 4'h0, 64'h200, 64'd0, 64'h100, 4'd4, 4'hF, 3'd1, 3'd1);
        chk("call_valE", M_valE, 64'hF8);
        step(0, 0, 3'd1, 4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'd4, 4'd5, 3'd1, 3'd1);
        chk("pop_valE", M_valE, 64'h108);
        step(1, 1, 3'd1, 4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'd2, 4'hF, 3'd1, 3'd1);
        chk("rst_bub_flags", {61'd0, ZF, SF, OF}, 64'b100);

        // back-to-back OPq, then a cmov that depends on the second result
        step(0, 0, 3'd1, 4'h6, 4'h1, 64'd0, 64'd3, 64'd1, 4'd2, 4'hF, 3'd1, 3'd1);
        step(0, 0, 3'd1, 4'h6, 4'h1, 64'd0, 64'd2, 64'd2, 4'd2, 4'hF, 3'd1, 3'd1);
        step(0, 0, 3'd1, 4'h2, 4'h3, 64'd0, 64'd9, 64'd0, 4'd6, 4'hF, 3'd1, 3'd1);
        chk("cmove_after_b2b", {60'd0, M_dstE}, 64'd6);

        // bubble alone does not block CC
        step(0, 1, 3'd1, 4'h6, 4'h2, 64'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             4'd2, 4'hF, 3'd1, 3'd1);
        chk("bubble_cc_SF", {63'd0, SF}, 64'd1);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] ms, ws;
            ms = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            ws = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            step($urandom_range(0, 40) == 0, $urandom_range(0, 10) == 0,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
                 rnd64(), rnd64(), rnd64(),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ms, ws);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/e_stage.md
E_STAGE -- requirements
Module: e_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have inputs e_stat[2:0], e_icode[3:0], e_ifun[3:0] (from E pipeline register).
REQ-004 SHALL have inputs e_valC[63:0], e_valA[63:0], e_valB[63:0] (from E pipeline register).
REQ-005 SHALL have inputs e_dstE[3:0] and e_dstM[3:0]: destination register IDs, 4'hF = none.
REQ-006 SHALL have inputs mem_stat[2:0] and wb_stat[2:0]: status of the instructions currently in Memory and Writeback.
REQ-007 SHALL have input M_bubble, 1 bit: inject a bubble into the M register at the next edge.
REQ-008 SHALL have combinational outputs ex_valE[63:0], ex_dstE[3:0] and ex_Cnd (1 bit), used for forwarding.
REQ-009 SHALL have registered outputs M_stat[2:0], M_icode[3:0], M_Cnd, M_valE[63:0], M_valA[63:0], M_dstE[3:0] and M_dstM[3:0].
REQ-010 SHALL have registered outputs ZF, SF and OF: the condition codes.

Function
REQ-011 Status encodings SHALL be AOK=1, HLT=2, ADR=3, INS=4; icodes SHALL follow Y86-64 (0 halt, 1 nop, 2 rrmov/cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, A push, B pop).
REQ-012 aluA SHALL be:
- e_valA for icode 2 and 6;
- e_valC for icode 3, 4 and 5;
- -8 for icode 8 and A;
- +8 for icode 9 and B;
- 0 otherwise.
REQ-013 aluB SHALL be e_valB for icodes 4, 5, 6, 8, 9, A and B, and 0 otherwise.
REQ-014 The ALU function SHALL be e_ifun when e_icode==6 and add otherwise, with ifun 0=add (B+A), 1=sub (B-A), 2=and, 3=xor, and 4-15 giving result 0.
REQ-015 ex_valE SHALL be the 64-bit ALU result, wrapping modulo 2^64 with no saturation.
REQ-016 set_cc SHALL equal (e_icode==6) AND mem_stat not in {HLT, ADR, INS} AND wb_stat not in {HLT, ADR, INS}.
REQ-017 When set_cc is true, at the edge: ZF <= (ex_valE==0) and SF <= ex_valE[63].
REQ-018 When set_cc is true, OF SHALL be loaded as follows:
- add: (A[63]==B[63]) && (R[63]!=A[63]);
- sub: (A[63]!=B[63]) && (R[63]!=B[63]);
- and, xor and invalid ifun: 0.
REQ-019 When set_cc is false, ZF, SF and OF SHALL hold their values.
REQ-020 The condition function on e_ifun SHALL be:
- 0: 1;
- 1: (SF^OF)|ZF;
- 2: SF^OF;
- 3: ZF;
- 4: ~ZF;
- 5: ~(SF^OF);
- 6: ~(SF^OF)&~ZF;
- 7-15: 0.
It SHALL use the registered (pre-update) CC values.
REQ-021 ex_Cnd SHALL be the condition function for icode 2 and 7, and 0 for all other icodes.
REQ-022 ex_dstE SHALL be 4'hF when e_icode==2 and ex_Cnd==0, and e_dstE otherwise.
REQ-023 Normal load (rst=0, M_bubble=0) SHALL register e_stat, e_icode, ex_Cnd, ex_valE, e_valA, ex_dstE and e_dstM into the corresponding M_* outputs at the edge, giving 1-cycle latency.
REQ-024 A bubble (M_bubble=1) SHALL load M_stat=1, M_icode=1, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=F and M_dstM=F.
REQ-025 A bubble SHALL NOT block a CC update in the same cycle; the CC update depends only on set_cc.
REQ-026 Priority SHALL be rst > M_bubble > normal load.
REQ-027 An instruction with e_stat != AOK SHALL still propagate to M unchanged; the only status-driven suppression SHALL be the CC inhibit of REQ-016.

Reset
REQ-028 With rst high at an edge, the M outputs SHALL take the bubble values of REQ-024, regardless of all other inputs.
REQ-029 With rst high at an edge, CC SHALL be set to ZF=1, SF=0, OF=0, regardless of all other inputs.
REQ-030 Asserting rst mid-stream SHALL discard any in-flight E contents with no partial update.
REQ-031 Combinational outputs SHALL reflect the current inputs and CC during reset.

Verification
REQ-032 OPq add, A=0x7FFFFFFFFFFFFFFF, B=1, stats AOK -> ex_valE=0x8000000000000000; next cycle ZF=0, SF=1, OF=1; M_valE matches.
REQ-033 OPq sub, A=5, B=5 -> ex_valE=0 and ZF=1, SF=0, OF=0; then jXX ifun=3 -> ex_Cnd=1, and jXX ifun=4 -> ex_Cnd=0.
REQ-034 cmovle (icode 2, ifun 1) with ZF=0, SF=0, OF=0 and e_dstE=3 -> ex_Cnd=0, ex_dstE=F, M_dstE=F.
REQ-035 OPq xor with mem_stat=ADR -> CC unchanged; M register still loads icode 6 with the xor result.
REQ-036 call with valB=0x100 -> ex_valE=0xF8; pop with valB=0x100 -> ex_valE=0x108; M_bubble=1 with rst=1 together -> reset values, CC=1/0/0.
REQ-037 Back-to-back OPq in consecutive cycles -> the second instruction's condition evaluation sees the CC written by the first instruction.
